// File: rtl/add_arbiter.sv
// Round-robin arbiter that time-shares one external combinational adder among NUM_REQ requesters.
// Optional `ADD_ARB_PRIO_EN gives requester 0 fixed top priority; the default build is pure round-robin.
module add_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] a_in,
    input  logic [NUM_REQ*DATA_W-1:0] b_in,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         add_a,
    output logic [DATA_W-1:0]         add_b,
    input  logic [DATA_W:0]           add_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W:0]           out_data,
    output logic [ID_W-1:0]           out_id
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] next_ptr;
    logic            found;
    int              idx;

    // Winner is the first active request scanning upward from rr_ptr with wrap-around.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx[ID_W-1:0]]) begin
                win   = idx[ID_W-1:0];
                found = 1'b1;
            end
        end
`ifdef ADD_ARB_PRIO_EN
        if (req[0]) begin
            win = '0;
        end
`endif
        next_ptr = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt    <= NUM_REQ'(1) << win;
                        add_a  <= a_in[int'(win)*DATA_W +: DATA_W];
                        add_b  <= b_in[int'(win)*DATA_W +: DATA_W];
                        out_id <= win;
`ifdef ADD_ARB_PRIO_EN
                        // Requester 0 wins outside the rotation, so it leaves the pointer alone.
                        if (!req[0]) begin
                            rr_ptr <= next_ptr;
                        end
`else
                        rr_ptr <= next_ptr;
`endif
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    out_data  <= add_out;
                    out_valid <= 1'b1;
                    gnt       <= '0;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_arbiter.sv
// Testbench for add_arbiter: directed and randomized operations checked against a transaction-level model.
// The shared adder is modelled here as a plain combinational add.
module tb_add_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 4;
    localparam int ID_W    = 2;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] a_in;
    logic [NUM_REQ*DATA_W-1:0] b_in;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         add_a;
    logic [DATA_W-1:0]         add_b;
    logic [DATA_W:0]           add_out;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W:0]           out_data;
    logic [ID_W-1:0]           out_id;

    int errors = 0;
    int checks = 0;

    int rr_ptr_m;
    int a_op[NUM_REQ];
    int b_op[NUM_REQ];

    add_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_out   (add_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    assign add_out = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference arbitration: first requester at or after the pointer, modulo NUM_REQ; -1 if none.
    function automatic int pick(input logic [NUM_REQ-1:0] r);
`ifdef ADD_ARB_PRIO_EN
        if (r[0]) return 0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r[(rr_ptr_m + i) % NUM_REQ]) return (rr_ptr_m + i) % NUM_REQ;
        end
        return -1;
    endfunction

    // One full transaction starting and ending at a falling edge with the arbiter idle.
    task automatic apply_stimulus(input logic [NUM_REQ-1:0] r, input int hold_cycles,
                                  input logic [NUM_REQ-1:0] hold_req);
        int w;
        int exp_sum;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_in[i*DATA_W +: DATA_W] = DATA_W'(a_op[i]);
            b_in[i*DATA_W +: DATA_W] = DATA_W'(b_op[i]);
        end
        req = r;
        w = pick(r);
        @(posedge clk);
        @(negedge clk);
        if (w < 0) begin
            check_output("idle_gnt", 32'(gnt), 32'd0);
            check_output("idle_valid", 32'(out_valid), 32'd0);
            return;
        end
        check_output("grant", 32'(gnt), 32'(1 << w));
        check_output("add_a", 32'(add_a), 32'(a_op[w]));
        check_output("add_b", 32'(add_b), 32'(b_op[w]));
        check_output("valid_low_at_grant", 32'(out_valid), 32'd0);
`ifdef ADD_ARB_PRIO_EN
        if (w != 0) rr_ptr_m = (w + 1) % NUM_REQ;
`else
        rr_ptr_m = (w + 1) % NUM_REQ;
`endif
        exp_sum = a_op[w] + b_op[w];
        @(posedge clk);
        @(negedge clk);
        check_output("gnt_pulse_end", 32'(gnt), 32'd0);
        check_output("valid", 32'(out_valid), 32'd1);
        check_output("data", 32'(out_data), 32'(exp_sum));
        check_output("id", 32'(out_id), 32'(w));
        req = hold_req;
        repeat (hold_cycles) begin
            @(posedge clk);
            @(negedge clk);
            check_output("hold_valid", 32'(out_valid), 32'd1);
            check_output("hold_data", 32'(out_data), 32'(exp_sum));
            check_output("hold_id", 32'(out_id), 32'(w));
            check_output("hold_gnt", 32'(gnt), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("accept_valid", 32'(out_valid), 32'd0);
        check_output("accept_gnt", 32'(gnt), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        a_in      = '0;
        b_in      = '0;
        out_ready = 1'b0;
        rr_ptr_m  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_op[i] = 0;
            b_op[i] = 0;
        end

        #12;
        check_output("rst_gnt", 32'(gnt), 32'd0);
        check_output("rst_add_a", 32'(add_a), 32'd0);
        check_output("rst_add_b", 32'(add_b), 32'd0);
        check_output("rst_valid", 32'(out_valid), 32'd0);
        check_output("rst_data", 32'(out_data), 32'd0);
        check_output("rst_id", 32'(out_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");

        a_op[0] = 3;
        b_op[0] = 4;
        apply_stimulus(4'b0001, 0, 4'b0000);

        a_op[2] = 15;
        b_op[2] = 15;
        apply_stimulus(4'b0100, 1, 4'b0000);

        // Backpressure: requester 1 asks while the result is stalled, then wins right after acceptance.
        a_op[1] = 9;
        b_op[1] = 6;
        apply_stimulus(4'b0001, 5, 4'b0010);
        apply_stimulus(4'b0010, 0, 4'b0000);

        // Reset while holding a result; the pointer must return to 0.
        req = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        check_output("pre_reset_grant", 32'(gnt), 32'(4'b0100));
        @(posedge clk);
        @(negedge clk);
        check_output("pre_reset_valid", 32'(out_valid), 32'd1);
        req = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_valid", 32'(out_valid), 32'd0);
        check_output("async_rst_gnt", 32'(gnt), 32'd0);
        check_output("async_rst_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rr_ptr_m = 0;
        @(posedge clk);
        @(negedge clk);
        check_output("no_result_after_reset", 32'(out_valid), 32'd0);

        // All four requesting continuously.
        for (int i = 0; i < NUM_REQ; i++) begin
            a_op[i] = i;
            b_op[i] = 1;
        end
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(4'b1111, 0, 4'b1111);
        end

        $display("[TB] randomized phase");
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                a_op[i] = int'($urandom_range(0, 15));
                b_op[i] = int'($urandom_range(0, 15));
            end
            apply_stimulus(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                           4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
Name: add_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational adder (a + b, carry-out kept) among NUM_REQ requesters.
- Each requester presents an operand pair. The block grants one requester at a time, drives the adder, and registers the sum together with the requester ID.
- The result is returned on a valid/ready output channel.
- Sits between testbench or agent requesters and the shared adder instance; the adder is external to this block.

Parameters:
- NUM_REQ, 4, number of requesters (minimum 2).
- DATA_W, 4, operand width; sum width is DATA_W+1.
- ID_W, $clog2(NUM_REQ), width of the requester ID (localparam).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request level.
- a_in  input  NUM_REQ*DATA_W  packed operand A; requester i uses slice [i*DATA_W +: DATA_W].
- b_in  input  NUM_REQ*DATA_W  packed operand B; same slicing as a_in.
- gnt  output  NUM_REQ  one-hot grant pulse, 1 cycle.
- add_a  output  DATA_W  registered operand A to the shared adder.
- add_b  output  DATA_W  registered operand B to the shared adder.
- add_out  input  DATA_W+1  sum returned from the shared adder (combinational).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  DATA_W+1  registered sum.
- out_id  output  ID_W  index of the requester that owns out_data.

Behaviour:
- Reset (async, rst_n=0): all outputs clear immediately.
  - gnt=0, add_a=0, add_b=0, out_valid=0, out_data=0, out_id=0.
  - state=IDLE, rr_ptr=0.
  - Any in-flight transaction is dropped; no result is produced for it.
- FSM states: IDLE, ISSUE, HOLD.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select winner w: the first set bit scanning upward from rr_ptr, wrapping from NUM_REQ-1 to 0.
  - On that edge: gnt <= onehot(w); add_a <= a_in[w]; add_b <= b_in[w]; out_id <= w; rr_ptr <= (w+1) mod NUM_REQ; state <= ISSUE.
- ISSUE (one cycle):
  - out_data <= add_out; out_valid <= 1; gnt <= 0; state <= HOLD.
- HOLD:
  - out_valid, out_data and out_id are held stable while out_ready=0.
  - On the edge where out_valid && out_ready: out_valid <= 0; state <= IDLE.
  - add_a and add_b keep their last values.
- Latency:
  - Request sampled at edge k.
  - gnt high during cycle k..k+1.
  - out_valid high from edge k+1.
  - Earliest accept at edge k+2; next grant no earlier than edge k+3.
  - Peak throughput: one operation per 3 cycles.
- Requester rules:
  - Hold req and operands stable until gnt is seen high.
  - gnt is the acknowledge; the requester drops req after it.
  - A req still high after its grant is treated as a new request.
- Arithmetic:
  - The sum is the unsigned full-width add_out; no truncation, no saturation.
  - Maximum sum is 2*(2^DATA_W-1), i.e. 30 at DATA_W=4.
- Boundary conditions:
  - All requesters active: grants rotate strictly 0,1,2,3,0,... with no starvation.
  - A single active requester is granted on every IDLE visit.
  - req changes during ISSUE or HOLD are ignored until IDLE.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Reset asserted in any state returns to IDLE with rr_ptr=0.

Optional Feature:
- Macro: ADD_ARB_PRIO_EN.
- Defined:
  - Requester 0 has fixed highest priority: if req[0]=1 in IDLE, w=0 regardless of rr_ptr.
  - rr_ptr is not updated on requester-0 grants.
  - Requesters 1..NUM_REQ-1 round-robin among themselves as above.
- Undefined: pure round-robin across all requesters; no priority logic is synthesised.

Test Plan:
- Single request: reset; req=4'b0001, a0=3, b0=4 -> gnt=0001 for 1 cycle, then out_valid=1, out_data=7, out_id=0; accept with out_ready=1 -> out_valid=0 next edge.
- Max operands: req[2]=1, a2=15, b2=15 -> out_data=5'd30 (carry kept), out_id=2.
- Round-robin: all four req held high with operands a_i=i, b_i=1, out_ready=1 -> grant order 0,1,2,3,0; out_data sequence 1,2,3,4,1; new grant every 3 cycles.
- Backpressure: result pending and out_ready=0 for 5 cycles while req[1] is asserted -> out_data and out_id stable, no new gnt; gnt[1] the cycle after acceptance is processed in IDLE.
- Reset mid-operation: assert rst_n=0 while in HOLD with out_valid=1 -> out_valid=0 immediately, gnt=0; after release, the next request is granted starting from requester 0.
- ADD_ARB_PRIO_EN defined: req=4'b1111 held with out_ready=1 -> requester 0 wins every arbitration; without the macro the order is 0,1,2,3.
